// File: rtl/ship_placer.sv
// ship_placer: places a fixed fleet of NUM_SHIPS ships on an 8x8 board.
// Each ship's row, column and direction come from the random source. A
// placement that would leave the board or overlap an earlier ship is
// retried. Accepted ships are committed into a 64-bit occupancy map.
// Optional feature macro: PLACER_RETRY_LIMIT_EN. When it is defined, a ship
// that is rejected MAX_TRIES times aborts the placement through FAIL.
module ship_placer #(
    parameter int NUM_SHIPS     = 4,
    parameter int SHIP_BASE_LEN = 2,
    parameter int SAMPLE_GAP    = 4,
    parameter int MAX_TRIES     = 15
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  rnd_posicao_orientacao,
    input  logic        rnd_direcao,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [63:0] board,
    output logic [2:0]  ships_placed
);

    localparam int GW = (SAMPLE_GAP > 1) ? $clog2(SAMPLE_GAP) : 1;
    localparam logic [GW-1:0] GAP_LAST  = GW'(SAMPLE_GAP - 1);
    localparam logic [3:0]    BASE_LEN  = 4'(SHIP_BASE_LEN);
    localparam logic [2:0]    FLEET     = 3'(NUM_SHIPS);
    localparam logic [7:0]    TRY_LIMIT = 8'(MAX_TRIES);
`ifdef PLACER_RETRY_LIMIT_EN
    localparam bit RETRY_LIMIT_EN = 1'b1;
`else
    localparam bit RETRY_LIMIT_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE,
        SAMPLE_ROW,
        SAMPLE_COL,
        CHECK,
        WRITE,
        DONE,
        FAIL
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [GW-1:0] gap_cnt;
    logic          gap_last;
    logic [2:0]    row;
    logic [2:0]    col;
    logic          dir;
    logic [7:0]    try_cnt;
    logic [7:0]    try_cnt_inc;
    logic [3:0]    len;
    logic [3:0]    end_pos;
    logic          in_bounds;
    logic          accept;
    logic          limit_hit;
    logic [63:0]   mask;
    logic [3:0]    r4;
    logic [3:0]    c4;
    logic [2:0]    ships_inc;
    logic          error_q;

    assign gap_last    = (gap_cnt == GAP_LAST);
    assign len         = BASE_LEN + {1'b0, ships_placed};
    assign ships_inc   = ships_placed + 3'd1;
    assign try_cnt_inc = try_cnt + 8'd1;
    assign limit_hit   = RETRY_LIMIT_EN && (try_cnt_inc == TRY_LIMIT);
    assign end_pos     = (dir ? {1'b0, row} : {1'b0, col}) + len - 4'd1;
    assign in_bounds   = (end_pos <= 4'd7);
    assign accept      = in_bounds && ((mask & board) == 64'd0);
    assign error       = error_q;

    // Build the cell mask of the candidate ship, dropping cells off the board
    always_comb begin
        mask = '0;
        r4   = '0;
        c4   = '0;
        for (int k = 0; k < 8; k++) begin
            r4 = {1'b0, row} + (dir ? 4'(k) : 4'd0);
            c4 = {1'b0, col} + (dir ? 4'd0 : 4'(k));
            if ((4'(k) < len) && (r4 < 4'd8) && (c4 < 4'd8))
                mask[{r4[2:0], c4[2:0]}] = 1'b1;
        end
    end

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state decoding and status outputs
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_next = SAMPLE_ROW;
            end
            SAMPLE_ROW: begin
                busy = 1'b1;
                if (gap_last) state_next = SAMPLE_COL;
            end
            SAMPLE_COL: begin
                busy = 1'b1;
                if (gap_last) state_next = CHECK;
            end
            CHECK: begin
                busy = 1'b1;
                if (accept)         state_next = WRITE;
                else if (limit_hit) state_next = FAIL;
                else                state_next = SAMPLE_ROW;
            end
            WRITE: begin
                busy = 1'b1;
                state_next = (ships_inc == FLEET) ? DONE : SAMPLE_ROW;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            FAIL: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath: sample capture, retry counting and board commits
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            gap_cnt      <= '0;
            row          <= '0;
            col          <= '0;
            dir          <= 1'b0;
            try_cnt      <= '0;
            board        <= '0;
            ships_placed <= '0;
            error_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    gap_cnt <= '0;
                    if (start) begin
                        board        <= '0;
                        ships_placed <= '0;
                        try_cnt      <= '0;
                        error_q      <= 1'b0;
                    end
                end
                SAMPLE_ROW: begin
                    if (gap_last) begin
                        row     <= rnd_posicao_orientacao;
                        gap_cnt <= '0;
                    end else begin
                        gap_cnt <= gap_cnt + GW'(1);
                    end
                end
                SAMPLE_COL: begin
                    if (gap_last) begin
                        col     <= rnd_posicao_orientacao;
                        dir     <= rnd_direcao;
                        gap_cnt <= '0;
                    end else begin
                        gap_cnt <= gap_cnt + GW'(1);
                    end
                end
                CHECK: begin
                    if (!accept) begin
                        try_cnt <= try_cnt_inc;
                        if (limit_hit) error_q <= 1'b1;
                    end
                end
                WRITE: begin
                    board        <= board | mask;
                    ships_placed <= ships_inc;
                    try_cnt      <= '0;
                end
                default: gap_cnt <= '0;
            endcase
        end
    end

endmodule
